// File: rtl/bcd_score_tracker.sv
// N-digit BCD score engine: clamped-step increment, saturation at all-nines,
// committed high score with new-record flag, and milestone/level tracking.
module bcd_score_tracker #(
   parameter int NUM_DIGITS      = 6,
   parameter int MILESTONE_DIGIT = 2,
   parameter int LEVEL_W         = 3,
   parameter int MAX_LEVEL       = 7
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      clear,
   input  logic                      inc_valid,
   input  logic [3:0]                inc_amount,
   input  logic                      commit,
   input  logic                      hs_clear,
   output logic [4*NUM_DIGITS-1:0]   score,
   output logic [4*NUM_DIGITS-1:0]   high_score,
   output logic                      new_record,
   output logic                      saturated,
   output logic                      milestone,
   output logic [LEVEL_W-1:0]        level
);

   localparam int SW = 4 * NUM_DIGITS;
   localparam int UL = 4 * MILESTONE_DIGIT;
   localparam logic [SW-1:0]      ALL_NINES = {NUM_DIGITS{4'h9}};
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

   logic [SW-1:0]      score_q, score_d;
   logic [SW-1:0]      high_score_q, high_score_d;
   logic               new_record_q, new_record_d;
   logic               saturated_q, saturated_d;
   logic               milestone_q, milestone_d;
   logic [LEVEL_W-1:0] level_q, level_d;

   logic [3:0]    step;
   logic [4:0]    dsum;
   logic          carry;
   logic [SW-1:0] sum_raw;
   logic [SW-1:0] inc_score;
   logic          accept;
   logic          upper_change;

   assign step = (inc_amount > 4'd9) ? 4'd9 : inc_amount;

   // Ripple the decimal carry through every digit in a single cycle.
   always_comb begin
      carry   = 1'b0;
      dsum    = '0;
      sum_raw = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         dsum = {1'b0, score_q[4*i +: 4]} + {4'b0, carry};
         if (i == 0) dsum = dsum + {1'b0, step};
         if (dsum > 5'd9) begin
            dsum  = dsum - 5'd10;
            carry = 1'b1;
         end else begin
            carry = 1'b0;
         end
         sum_raw[4*i +: 4] = dsum[3:0];
      end
   end

   assign inc_score    = carry ? ALL_NINES : sum_raw;
   assign accept       = inc_valid && !clear && !saturated_q && (step != 4'd0);
   assign upper_change = inc_score[SW-1:UL] != score_q[SW-1:UL];

   always_comb begin
      score_d      = score_q;
      high_score_d = high_score_q;
      new_record_d = new_record_q;
      saturated_d  = saturated_q;
      milestone_d  = 1'b0;
      level_d      = level_q;

      if (clear) begin
         score_d      = '0;
         saturated_d  = 1'b0;
         level_d      = '0;
         new_record_d = 1'b0;
      end else if (accept) begin
         score_d = inc_score;
         if (carry) saturated_d = 1'b1;
         if (upper_change) begin
            milestone_d = 1'b1;
            if (level_q < LEVEL_MAX) level_d = level_q + 1'b1;
         end
      end

      // Commit sees the pre-update score and its flag result overrides clear.
      if (hs_clear) begin
         high_score_d = '0;
         new_record_d = 1'b0;
      end else if (commit) begin
         if (score_q > high_score_q) begin
            high_score_d = score_q;
            new_record_d = 1'b1;
         end else begin
            new_record_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         score_q      <= '0;
         high_score_q <= '0;
         new_record_q <= 1'b0;
         saturated_q  <= 1'b0;
         milestone_q  <= 1'b0;
         level_q      <= '0;
      end else begin
         score_q      <= score_d;
         high_score_q <= high_score_d;
         new_record_q <= new_record_d;
         saturated_q  <= saturated_d;
         milestone_q  <= milestone_d;
         level_q      <= level_d;
      end
   end

   assign score      = score_q;
   assign high_score = high_score_q;
   assign new_record = new_record_q;
   assign saturated  = saturated_q;
   assign milestone  = milestone_q;
   assign level      = level_q;

endmodule

// File: tb/tb_bcd_score_tracker.sv
// Bench for bcd_score_tracker: a 6-digit and a 2-digit instance share stimulus,
// each tracked by an integer-arithmetic model, plus directed literal checks.
module tb_bcd_score_tracker;

   logic       clk = 1'b0;
   logic       resetn, clear, inc_valid, commit, hs_clear;
   logic [3:0] inc_amount;

   logic [23:0] score_b, hs_b;
   logic        nr_b, sat_b, ms_b;
   logic [2:0]  lvl_b;
   logic [7:0]  score_s, hs_s;
   logic        nr_s, sat_s, ms_s;
   logic [1:0]  lvl_s;

   int checks = 0;
   int errors = 0;
   bit go = 0;

   always #5 clk = ~clk;

   bcd_score_tracker #(.NUM_DIGITS(6), .MILESTONE_DIGIT(2), .LEVEL_W(3), .MAX_LEVEL(7)) dut_b (
      .clk(clk), .resetn(resetn), .clear(clear), .inc_valid(inc_valid),
      .inc_amount(inc_amount), .commit(commit), .hs_clear(hs_clear),
      .score(score_b), .high_score(hs_b), .new_record(nr_b),
      .saturated(sat_b), .milestone(ms_b), .level(lvl_b));

   bcd_score_tracker #(.NUM_DIGITS(2), .MILESTONE_DIGIT(1), .LEVEL_W(2), .MAX_LEVEL(3)) dut_s (
      .clk(clk), .resetn(resetn), .clear(clear), .inc_valid(inc_valid),
      .inc_amount(inc_amount), .commit(commit), .hs_clear(hs_clear),
      .score(score_s), .high_score(hs_s), .new_record(nr_s),
      .saturated(sat_s), .milestone(ms_s), .level(lvl_s));

   typedef struct {
      int score;
      int hs;
      int level;
      bit sat;
      bit nr;
      bit ms;
   } model_t;

   model_t mb = '{0, 0, 0, 0, 0, 0};
   model_t msm = '{0, 0, 0, 0, 0, 0};

   // Score kept as a plain integer; saturation and milestones come from decimal arithmetic.
   function automatic model_t mstep(model_t m, bit rn, bit clr, bit iv, logic [3:0] amt,
                                    bit cm, bit hsc, int maxv, int div, int maxl);
      model_t n;
      int st;
      int s;
      n = m;
      n.ms = 0;
      if (!rn) begin
         n = '{0, 0, 0, 0, 0, 0};
         return n;
      end
      st = (int'(amt) > 9) ? 9 : int'(amt);
      if (clr) begin
         n.score = 0; n.level = 0; n.sat = 0; n.nr = 0;
      end else if (iv && !m.sat && st != 0) begin
         s = m.score + st;
         if (s > maxv) begin
            s = maxv;
            n.sat = 1;
         end
         if (s / div != m.score / div) begin
            n.ms = 1;
            if (n.level < maxl) n.level = n.level + 1;
         end
         n.score = s;
      end
      if (hsc) begin
         n.hs = 0; n.nr = 0;
      end else if (cm) begin
         if (m.score > m.hs) begin
            n.hs = m.score; n.nr = 1;
         end else begin
            n.nr = 0;
         end
      end
      return n;
   endfunction

   function automatic logic [31:0] to_bcd(int val, int nd);
      logic [31:0] r;
      int v;
      r = '0;
      v = val;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic bit all_bcd(logic [31:0] v, int nd);
      for (int i = 0; i < nd; i++)
         if (!(v[4*i +: 4] <= 4'd9)) return 0;
      return 1;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      mb  <= mstep(mb,  resetn, clear, inc_valid, inc_amount, commit, hs_clear, 999999, 100, 7);
      msm <= mstep(msm, resetn, clear, inc_valid, inc_amount, commit, hs_clear, 99, 10, 3);
      go  <= 1'b1;
   end

   always @(negedge clk) begin
      if (go) begin
         chk("m_score_b", score_b, to_bcd(mb.score, 6));
         chk("m_hs_b",    hs_b,    to_bcd(mb.hs, 6));
         chk("m_nr_b",    nr_b,    mb.nr);
         chk("m_sat_b",   sat_b,   mb.sat);
         chk("m_ms_b",    ms_b,    mb.ms);
         chk("m_lvl_b",   lvl_b,   mb.level);
         chk("m_bcd_b",   all_bcd(score_b, 6) && all_bcd(hs_b, 6), 1);
         chk("m_score_s", score_s, to_bcd(msm.score, 2));
         chk("m_hs_s",    hs_s,    to_bcd(msm.hs, 2));
         chk("m_nr_s",    nr_s,    msm.nr);
         chk("m_sat_s",   sat_s,   msm.sat);
         chk("m_ms_s",    ms_s,    msm.ms);
         chk("m_lvl_s",   lvl_s,   msm.level);
         chk("m_bcd_s",   all_bcd(score_s, 2) && all_bcd(hs_s, 2), 1);
      end
   end

   task automatic cyc(bit c, bit iv, logic [3:0] a, bit cm, bit hc);
      clear = c; inc_valid = iv; inc_amount = a; commit = cm; hs_clear = hc;
      @(posedge clk);
      #1;
   endtask

   task automatic incs(int n, logic [3:0] a);
      for (int i = 0; i < n; i++) cyc(0, 1, a, 0, 0);
   endtask

   initial begin
      resetn = 1'b0;
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("rst_score", score_b, 0);
      chk("rst_level", lvl_b, 0);
      resetn = 1'b1;

      incs(11, 9);
      chk("pre12_score", score_b, 32'h99);
      chk("pre12_lvl", lvl_b, 0);
      incs(1, 9);
      chk("p12_score", score_b, 32'h108);
      chk("p12_ms", ms_b, 1);
      chk("p12_lvl", lvl_b, 1);
      cyc(0, 0, 0, 0, 0);
      chk("p12_ms_drop", ms_b, 0);
      cyc(0, 1, 0, 0, 0);
      chk("zero_inc", score_b, 32'h108);

      cyc(1, 0, 0, 0, 0);
      incs(10, 9);
      incs(1, 5);
      incs(1, 7);
      chk("sat_s_score", score_s, 32'h99);
      chk("sat_s_flag", sat_s, 1);
      incs(1, 1);
      chk("sat_s_hold", score_s, 32'h99);
      chk("sat_s_noms", ms_s, 0);
      cyc(1, 0, 0, 0, 0);
      chk("sat_s_clr", sat_s, 0);

      incs(10, 9);
      incs(1, 5);
      incs(1, 13);
      chk("clamp_score", score_b, 32'h104);
      chk("clamp_ms", ms_b, 1);
      chk("clamp_lvl", lvl_b, 1);

      cyc(1, 0, 0, 0, 0);
      incs(100, 9);
      chk("lvl_sat_score", score_b, 32'h900);
      chk("lvl_sat_ms", ms_b, 1);
      chk("lvl_sat_lvl", lvl_b, 7);
      cyc(1, 1, 9, 0, 0);
      chk("clr_inc_score", score_b, 0);
      chk("clr_inc_lvl", lvl_b, 0);
      chk("clr_inc_ms", ms_b, 0);

      incs(27, 9);
      incs(1, 7);
      cyc(0, 1, 5, 1, 0);
      chk("cm1_hs", hs_b, 32'h250);
      chk("cm1_nr", nr_b, 1);
      chk("cm1_score", score_b, 32'h255);
      cyc(0, 0, 0, 1, 0);
      chk("cm2_hs", hs_b, 32'h255);
      cyc(1, 0, 0, 0, 0);
      incs(1, 9);
      cyc(0, 0, 0, 1, 0);
      chk("cm3_nr", nr_b, 0);
      chk("cm3_hs", hs_b, 32'h255);

      incs(30, 9);
      cyc(1, 0, 0, 1, 0);
      chk("cmclr_hs", hs_b, 32'h279);
      chk("cmclr_nr", nr_b, 1);
      chk("cmclr_score", score_b, 0);

      incs(33, 9);
      incs(1, 3);
      cyc(0, 0, 0, 1, 1);
      chk("hsc_hs", hs_b, 0);
      chk("hsc_nr", nr_b, 0);
      cyc(0, 0, 0, 1, 0);
      chk("hs300", hs_b, 32'h300);
      incs(3, 4);
      resetn = 1'b0;
      cyc(0, 1, 9, 1, 0);
      chk("mid_rst_score", score_b, 0);
      chk("mid_rst_hs", hs_b, 0);
      chk("mid_rst_nr", nr_b, 0);
      resetn = 1'b1;
      cyc(0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
